// File: rtl/game_pkg.sv
// Shared types and defaults for the health/award control path.
package game_pkg;

    typedef logic [6:0]  health_t;
    typedef logic [26:0] rate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DEAD  = 2'd3
    } award_state_e;

    localparam rate_t DEFAULT_BASE_RATE = 27'd50_000_000;
    localparam rate_t DEFAULT_MIN_RATE  = 27'd10_000_000;

endpackage

// File: rtl/health_award_ctrl_if.sv
// Answer-checker and health-counter signals seen by the award controller.
interface health_award_ctrl_if;
    import game_pkg::*;

    logic       answer_valid;
    logic       answer_correct;
    health_t    current_health;
    logic       no_health;
    logic       add_health;
    rate_t      health_rate;
    logic [3:0] level;
    logic [3:0] pending;
    logic       game_over;

    modport master (
        output answer_valid, answer_correct, current_health, no_health,
        input  add_health, health_rate, level, pending, game_over
    );

    modport slave (
        input  answer_valid, answer_correct, current_health, no_health,
        output add_health, health_rate, level, pending, game_over
    );

endinterface

// File: rtl/award_pulse_gen.sv
// Pending-point queue and the pulse sequencer that spaces add_health pulses.
//   state | meaning
//   IDLE  | nothing queued
//   PULSE | add_health high this cycle, one point leaves the queue
//   GAP   | PULSE_GAP quiet cycles before the next pulse may fire
//   DEAD  | health exhausted; queue flushed, held until reset
module award_pulse_gen
    import game_pkg::*;
#(
    parameter int unsigned PULSE_GAP = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] grant,
    input  logic       kill,
    output logic       add_health,
    output logic [3:0] pending,
    output logic       dead
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_PULSE = PULSE;
    localparam logic [1:0] ST_GAP   = GAP;
    localparam logic [1:0] ST_DEAD  = DEAD;
    localparam logic [7:0] GAP_LOAD = (PULSE_GAP > 0) ? 8'(PULSE_GAP - 1) : 8'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [4:0] net;

    always_comb begin
        add_health = (state_q == ST_PULSE);
        net        = 5'(pending_q) + 5'(grant) - 5'(add_health);
        pending_d  = (net > 5'd15) ? 4'd15 : net[3:0];
        state_d    = state_q;
        gap_cnt_d  = gap_cnt_q;

        // Decisions look at pending_d so a same-cycle grant can fire next cycle.
        case (state_q)
            ST_IDLE: begin
                if (pending_d != 4'd0) state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (PULSE_GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = (pending_d != 4'd0) ? ST_PULSE : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != 8'd0) gap_cnt_d = gap_cnt_q - 8'd1;
                else state_d = (pending_d != 4'd0) ? ST_PULSE : ST_IDLE;
            end
            default: begin
                pending_d = 4'd0;
            end
        endcase

        if (kill) begin
            state_d   = ST_DEAD;
            pending_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 4'd0;
            gap_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign pending = pending_q;
    assign dead    = (state_q == ST_DEAD);

endmodule

// File: rtl/health_award_ctrl.sv
// Turns graded answers into spaced health pulses and a level-driven decay rate.
// Optional STREAK_BONUS_EN: every third consecutive correct answer earns one extra point.
module health_award_ctrl
    import game_pkg::*;
#(
    parameter int unsigned REWARD_HP  = 3,
    parameter int unsigned MAX_HEALTH = 99,
    parameter int unsigned PULSE_GAP  = 4,
    parameter rate_t       BASE_RATE  = DEFAULT_BASE_RATE,
    parameter int unsigned RATE_STEP  = 4_000_000,
    parameter rate_t       MIN_RATE   = DEFAULT_MIN_RATE,
    parameter int unsigned LEVEL_STEP = 5,
    parameter int unsigned MAX_LEVEL  = 10
) (
    input  logic                clk,
    input  logic                reset,
    health_award_ctrl_if.slave  bus
);

    logic [3:0] pending, grant, level_q, level_d;
    logic       add_health, add_health_q, dead, accept, bonus;
    logic [7:0] correct_cnt_q, correct_cnt_d, used, headroom, reward;
    rate_t      health_rate_q, health_rate_d;
    logic [31:0] rate_dec, rate_raw;

    assign accept = bus.answer_valid & ~bus.no_health & ~dead;

`ifdef STREAK_BONUS_EN
    logic [1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        bonus    = 1'b0;
        if (accept) begin
            if (!bus.answer_correct) begin
                streak_d = 2'd0;
            end else if (streak_q == 2'd2) begin
                streak_d = 2'd0;
                bonus    = 1'b1;
            end else begin
                streak_d = streak_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) streak_q <= 2'd0;
        else       streak_q <= streak_d;
    end
`else
    assign bonus = 1'b0;
`endif

    // The counter lags a pulse by one cycle, so last cycle's pulse still counts as used.
    always_comb begin
        used          = 8'(bus.current_health) + 8'(pending) + 8'(add_health_q);
        headroom      = (8'(MAX_HEALTH) > used) ? 8'(MAX_HEALTH) - used : 8'd0;
        reward        = 8'(REWARD_HP) + 8'(bonus);
        grant         = 4'd0;
        correct_cnt_d = correct_cnt_q;
        level_d       = level_q;
        if (accept && bus.answer_correct) begin
            grant = (reward < headroom) ? 4'(reward) : 4'(headroom);
            if (correct_cnt_q + 8'd1 >= 8'(LEVEL_STEP)) begin
                correct_cnt_d = 8'd0;
                if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
            end else begin
                correct_cnt_d = correct_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        rate_dec      = 32'(level_q) * 32'(RATE_STEP);
        rate_raw      = (rate_dec < 32'(BASE_RATE)) ? 32'(BASE_RATE) - rate_dec : 32'd0;
        health_rate_d = (rate_raw > 32'(MIN_RATE)) ? rate_t'(rate_raw) : MIN_RATE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            add_health_q  <= 1'b0;
            correct_cnt_q <= 8'd0;
            level_q       <= 4'd0;
            health_rate_q <= BASE_RATE;
        end else begin
            add_health_q  <= add_health;
            correct_cnt_q <= correct_cnt_d;
            level_q       <= level_d;
            health_rate_q <= health_rate_d;
        end
    end

    award_pulse_gen #(
        .PULSE_GAP (PULSE_GAP)
    ) u_pulse_gen (
        .clk        (clk),
        .reset      (reset),
        .grant      (grant),
        .kill       (bus.no_health),
        .add_health (add_health),
        .pending    (pending),
        .dead       (dead)
    );

    assign bus.add_health  = add_health;
    assign bus.pending     = pending;
    assign bus.level       = level_q;
    assign bus.health_rate = health_rate_q;
    assign bus.game_over   = dead;

endmodule

// File: tb/tb_health_award_ctrl.sv
// Scoreboard bench for health_award_ctrl: a throttled-queue reference model predicts pulses.
module tb_health_award_ctrl;
    import game_pkg::*;

    localparam int     REWARD_HP  = 3;
    localparam int     MAX_HEALTH = 99;
    localparam int     PULSE_GAP  = 4;
    localparam int     LEVEL_STEP = 5;
    localparam int     MAX_LEVEL  = 10;
    localparam longint BASE_RATE  = 50_000_000;
    localparam longint RATE_STEP  = 4_000_000;
    localparam longint MIN_RATE   = 10_000_000;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    health_award_ctrl_if bus();

    health_award_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int pend;
    } pulse_t;

    pulse_t  exp_q[$];
    int      pulse_cyc[$];
    int      cyc = 0;
    int      n_tests = 0;
    int      n_fail = 0;
    health_t cur_h = '0;

    // reference model: points waiting, last pulse time, level bookkeeping
    int     m_pend, m_last, m_level, m_level_prev, m_cnt, m_streak;
    bit     m_dead, m_addq;
    int     exp_pend_now, exp_level_now;
    longint exp_rate_now;
    bit     exp_dead_now;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint rate_of(input int lvl);
        longint r = BASE_RATE - longint'(lvl) * RATE_STEP;
        return (r < MIN_RATE) ? MIN_RATE : r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_last = -1000; m_level = 0; m_level_prev = 0;
        m_cnt = 0; m_streak = 0; m_dead = 0; m_addq = 0;
    endtask

    task automatic model_cycle(input bit av, input bit ac, input bit nh, input health_t ch);
        bit pulse;
        int head, reward, grant;
        exp_pend_now  = m_pend;
        exp_level_now = m_level;
        exp_rate_now  = rate_of(m_level_prev);
        exp_dead_now  = m_dead;
        // a queued point fires once at least PULSE_GAP quiet cycles followed the last one
        pulse = !m_dead && (m_pend > 0) && (cyc - m_last > PULSE_GAP);
        if (pulse) begin
            exp_q.push_back('{cyc, m_pend});
            m_last = cyc;
        end
        grant = 0;
        m_level_prev = m_level;
        if (nh || m_dead) begin
            m_dead = 1;
            m_pend = 0;
        end else begin
            if (av && ac) begin
                head = MAX_HEALTH - int'(ch) - m_pend - int'(m_addq);
                if (head < 0) head = 0;
                reward = REWARD_HP;
`ifdef STREAK_BONUS_EN
                if (m_streak == 2) begin
                    reward++;
                    m_streak = 0;
                end else begin
                    m_streak++;
                end
`endif
                grant = (reward < head) ? reward : head;
                m_cnt++;
                if (m_cnt == LEVEL_STEP) begin
                    m_cnt = 0;
                    if (m_level < MAX_LEVEL) m_level++;
                end
            end else if (av) begin
                m_streak = 0;
            end
            m_pend = m_pend + grant - (pulse ? 1 : 0);
            if (m_pend > 15) m_pend = 15;
        end
        m_addq = pulse;
    endtask

    task automatic step(input bit av, input bit ac, input bit nh);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.answer_valid   = av;
        bus.answer_correct = ac;
        bus.no_health      = nh;
        bus.current_health = cur_h;
        model_cycle(av, ac, nh, cur_h);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            bus.answer_valid   = 1'b0;
            bus.answer_correct = 1'b0;
            bus.no_health      = 1'b0;
        end
        model_reset();
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        chk({tag, ".pending"},   bus.pending,     exp_pend_now);
        chk({tag, ".level"},     bus.level,       exp_level_now);
        chk({tag, ".rate"},      bus.health_rate, exp_rate_now);
        chk({tag, ".game_over"}, bus.game_over,   exp_dead_now);
    endtask

    // monitor: every add_health pulse must match the head of the expected queue
    always @(negedge clk) begin
        pulse_t e;
        if (!reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_pulse: add_health=0 at cycle %0d, expected 1 with pending %0d", e.cyc, e.pend);
            end
            if (bus.add_health === 1'b1) begin
                pulse_cyc.push_back(cyc);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse: add_health=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.pend != int'(bus.pending)) begin
                        n_fail++;
                        $display("FAIL pulse: got cycle %0d pending %0d, expected cycle %0d pending %0d", cyc, bus.pending, e.cyc, e.pend);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t, base;
        bus.answer_valid   = 1'b0;
        bus.answer_correct = 1'b0;
        bus.no_health      = 1'b0;
        bus.current_health = '0;
        model_reset();

        // reset values, then one answer at health 20
        do_reset();
        cur_h = 7'd20;
        step(0, 0, 0);
        check_state("reset");
        chk("reset.add_health", bus.add_health, 0);
        chk("reset.rate_const", bus.health_rate, 50_000_000);
        base = pulse_cyc.size();
        step(1, 1, 0);
        t = cyc;
        step(0, 0, 0);
        check_state("single");
        chk("single.pending3", bus.pending, 3);
        idle(14);
        chk("single.pulses", pulse_cyc.size() - base, 3);
        if (pulse_cyc.size() - base == 3) begin
            chk("single.first_at_+1",  pulse_cyc[base] - t, 1);
            chk("single.second_at_+6", pulse_cyc[base + 1] - t, 6);
            chk("single.third_at_+11", pulse_cyc[base + 2] - t, 11);
        end
        check_state("single_drained");

        // near the ceiling: headroom limits the grant
        do_reset();
        cur_h = 7'd97;
        base = pulse_cyc.size();
        step(1, 1, 0);
        step(1, 1, 0);
        idle(14);
        chk("ceiling.pulses", pulse_cyc.size() - base, 2);
        check_state("ceiling");

        // levels and decay rate
        do_reset();
        cur_h = 7'd99;
        repeat (5) step(1, 1, 0);
        step(0, 0, 0);
        check_state("level1");
        chk("level1.level", bus.level, 1);
        step(0, 0, 0);
        check_state("level1_rate");
        chk("level1.rate_const", bus.health_rate, 46_000_000);
        repeat (55) step(1, 1, 0);
        idle(2);
        check_state("level10");
        chk("level10.level", bus.level, 10);
        chk("level10.rate_floor", bus.health_rate, 10_000_000);

        // grant landing on a pulse cycle
        do_reset();
        cur_h = 7'd20;
        base = pulse_cyc.size();
        step(1, 1, 0);
        idle(5);
        step(1, 1, 0);
        check_state("overlap");
        chk("overlap.pulse_now", bus.add_health, 1);
        chk("overlap.pending2", bus.pending, 2);
        step(0, 0, 0);
        check_state("overlap_next");
        chk("overlap.pending4", bus.pending, 4);
        idle(30);
        chk("overlap.pulses", pulse_cyc.size() - base, 6);

        // death mid-gap
        do_reset();
        cur_h = 7'd20;
        base = pulse_cyc.size();
        step(1, 1, 0);
        step(0, 0, 0);
        cur_h = 7'd95;
        step(1, 1, 0);
        step(0, 0, 1);
        check_state("kill");
        chk("kill.pending3", bus.pending, 3);
        chk("kill.in_gap", bus.add_health, 0);
        step(1, 1, 1);
        check_state("dead");
        chk("dead.game_over", bus.game_over, 1);
        chk("dead.pending0", bus.pending, 0);
        repeat (10) step(1, 1, 0);
        check_state("dead_ignore");
        chk("dead_ignore.level", bus.level, 0);
        idle(10);
        chk("dead.pulses", pulse_cyc.size() - base, 1);
        do_reset();
        step(0, 0, 0);
        check_state("after_dead_reset");
        chk("after_dead_reset.game_over", bus.game_over, 0);

`ifdef STREAK_BONUS_EN
        do_reset();
        cur_h = 7'd20;
        base = pulse_cyc.size();
        repeat (3) step(1, 1, 0);
        idle(60);
        chk("streak.ccc_pulses", pulse_cyc.size() - base, 10);
        do_reset();
        base = pulse_cyc.size();
        step(1, 1, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        idle(60);
        chk("streak.cwcc_pulses", pulse_cyc.size() - base, 9);
`endif

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bit av, ac, nh;
            if (($urandom % 16) == 0) cur_h = health_t'($urandom_range(0, 105));
            av = (($urandom % 4) == 0);
            ac = (($urandom % 5) != 0);
            nh = (($urandom % 500) == 0);
            if (m_dead && (($urandom % 20) == 0)) do_reset();
            step(av, ac, nh);
            if ((i % 10) == 0) check_state("rand");
        end

        idle(80);
        check_state("final");
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
